// File: rtl/stimulus_checker.sv
// Receive-side checker: accepts a WIDTH-bit sample stream over valid/ready and compares each
// sample against a seeded rotating ring pattern, reporting mismatch count and first failure.
module stimulus_checker #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NUM_CHECKS = 16,
  parameter int unsigned CW         = $clog2(NUM_CHECKS + 1),
  parameter int unsigned IW         = $clog2(NUM_CHECKS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic             dir,
  input  logic             number_valid,
  input  logic [WIDTH-1:0] number,
  output logic             number_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    err_count,
  output logic [IW-1:0]    first_err_index,
  output logic [WIDTH-1:0] first_err_value,
  output logic [WIDTH-1:0] first_err_expected
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [IW-1:0] LastIdx = IW'(NUM_CHECKS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [IW-1:0]    index_q, index_d;
  logic             dir_q, dir_d;
  logic             pass_q, pass_d;
  logic [CW-1:0]    err_count_q, err_count_d;
  logic [IW-1:0]    ferr_index_q, ferr_index_d;
  logic [WIDTH-1:0] ferr_value_q, ferr_value_d;
  logic [WIDTH-1:0] ferr_expected_q, ferr_expected_d;

  logic accept, mismatch, last, launch;

  // Handshake decoded purely from state so ready never depends on valid.
  assign accept   = number_valid & (state_q == StRun);
  assign mismatch = (number != expected_q);
  assign last     = (index_q == LastIdx);
  assign launch   = start & (state_q != StRun);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StRun;
      StRun:          if (accept && last) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    number_ready = (state_q == StRun);
    busy         = (state_q == StRun);
    done         = (state_q == StDone);
  end

  // Datapath next-state
  always_comb begin
    expected_d      = expected_q;
    index_d         = index_q;
    dir_d           = dir_q;
    pass_d          = pass_q;
    err_count_d     = err_count_q;
    ferr_index_d    = ferr_index_q;
    ferr_value_d    = ferr_value_q;
    ferr_expected_d = ferr_expected_q;
    if (launch) begin
      expected_d      = seed;
      dir_d           = dir;
      index_d         = '0;
      pass_d          = 1'b0;
      err_count_d     = '0;
      ferr_index_d    = '0;
      ferr_value_d    = '0;
      ferr_expected_d = '0;
    end else if (accept) begin
      err_count_d = err_count_q + CW'(mismatch);
      if (mismatch && (err_count_q == '0)) begin
        ferr_index_d    = index_q;
        ferr_value_d    = number;
        ferr_expected_d = expected_q;
      end
      expected_d = dir_q ? {expected_q[WIDTH-2:0], expected_q[WIDTH-1]}
                         : {expected_q[0], expected_q[WIDTH-1:1]};
      index_d    = index_q + IW'(1);
      // Final verdict includes the last sample, so use the updated count.
      if (last) pass_d = (err_count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      expected_q      <= '0;
      index_q         <= '0;
      dir_q           <= 1'b0;
      pass_q          <= 1'b0;
      err_count_q     <= '0;
      ferr_index_q    <= '0;
      ferr_value_q    <= '0;
      ferr_expected_q <= '0;
    end else begin
      expected_q      <= expected_d;
      index_q         <= index_d;
      dir_q           <= dir_d;
      pass_q          <= pass_d;
      err_count_q     <= err_count_d;
      ferr_index_q    <= ferr_index_d;
      ferr_value_q    <= ferr_value_d;
      ferr_expected_q <= ferr_expected_d;
    end
  end

  assign pass               = pass_q;
  assign err_count          = err_count_q;
  assign first_err_index    = ferr_index_q;
  assign first_err_value    = ferr_value_q;
  assign first_err_expected = ferr_expected_q;

endmodule

// File: doc/stimulus_checker.md
Name: stimulus_checker

Overview:
- Receive end of the stimulus path. The stimulus block drives an 8-bit `number` stream; this block consumes it over a valid/ready handshake.
- Each accepted value is compared against an internally generated expected sequence. The sequence is a rotating ring pattern loaded from a seed and shifted left or right per sample.
- Counts mismatches, captures the first failure and reports pass/fail at the end of a fixed-length run.
- Sits beside the stimulus block in sample benches as its self-checking counterpart.

Parameters:
- WIDTH, 8, data width of `number` and of the expected pattern.
- NUM_CHECKS, 16, samples accepted per run (>=2).
- CW, $clog2(NUM_CHECKS+1), width of err_count.
- IW, $clog2(NUM_CHECKS), width of sample index.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run (honoured in IDLE or DONE only).
- seed  input  WIDTH  initial expected value, sampled on accepted start.
- dir  input  1  1 = rotate left per sample, 0 = rotate right; sampled on accepted start.
- number_valid  input  1  producer has a sample on `number`.
- number  input  WIDTH  sample data.
- number_ready  output  1  checker accepts a sample this cycle.
- busy  output  1  run in progress.
- done  output  1  run complete, results stable.
- pass  output  1  valid when done; 1 if err_count == 0.
- err_count  output  CW  mismatches in current/last run.
- first_err_index  output  IW  index of first mismatching sample.
- first_err_value  output  WIDTH  received value at first mismatch.
- first_err_expected  output  WIDTH  expected value at first mismatch.

Behaviour:
- Reset (reset=1 at posedge) has priority over every other input and aborts any run.
  - Next state is IDLE.
  - busy, done, pass, err_count, first_err_* and the internal expected, index and dir registers all go to 0.
  - number_ready is 0.
- Control is a three-state machine: IDLE, RUN, DONE.
- number_ready = (state == RUN). It is decoded from the state register with no combinational path from number_valid.
- Accept = number_valid & number_ready. Data is ignored whenever accept is 0.
- IDLE or DONE with start=1, at the edge:
  - Load expected<=seed and dir_q<=dir.
  - Clear index, err_count, first_err_* and pass; clear done.
  - Set busy; go to RUN.
  - number_ready is therefore first high in the cycle after start.
- RUN with start=1: start is ignored and the run continues unaffected.
- RUN, on each accept:
  - Mismatch is number != expected. On a mismatch, err_count increments by 1; it cannot overflow, since its maximum is NUM_CHECKS.
  - If the mismatch is the first of the run (err_count == 0 before the edge), capture first_err_index<=index, first_err_value<=number and first_err_expected<=expected.
  - Advance expected: dir_q=1 gives {e[W-2:0], e[W-1]}; dir_q=0 gives {e[0], e[W-1:1]}.
  - index increments.
- End of run: when accept occurs with index == NUM_CHECKS-1, go to DONE at that edge.
  - busy<=0, done<=1.
  - pass<=1 only if no mismatch occurred, including the final sample (use the updated count).
  - done therefore rises the cycle after the last accept; number_ready drops in the same cycle.
- DONE holds all results until start or reset.
- Boundary cases:
  - Seed of all-zeros or all-ones is legal; expected stays constant.
  - Back-to-back accepts every cycle are supported; valid gaps simply stall the run.
  - A start pulse arriving in the same cycle DONE is entered is ignored.
  - The first_err_* outputs are meaningful only when err_count != 0.

Test Plan:
- Clean left rotation: WIDTH=8, NUM_CHECKS=16, seed=8'h01, dir=1; drive 01,02,04,…,80,01,…,80 continuously.
  - Expect 16 accepts and done high one cycle after the last.
  - Expect pass=1, err_count=0.
- Single error: same as above, but send 8'h00 at index 5 (expected 8'h20).
  - Expect err_count=1, first_err_index=5, first_err_value=8'h00, first_err_expected=8'h20, pass=0.
- Right rotation with two errors: seed=8'h81, dir=0; expected sequence is 81,C0,60,30,18,…
  - Corrupt index 3 (send 8'hFF) and index 9.
  - Expect err_count=2, first_err_index=3, first_err_value=8'hFF, first_err_expected=8'h30.
- Valid gaps: as the clean run, but number_valid toggles every other cycle, and a wrong value is held on `number` while valid=0.
  - Expect pass=1 and no extra accepts.
- Reset mid-run: assert reset after 7 accepts.
  - Next cycle expect all outputs 0 and number_ready=0.
  - A new start plus a clean 16-sample run then gives pass=1.
- Start during RUN: pulse start with seed=8'h55 at index 4.
  - Expect it to be ignored; the original sequence continues; clean data gives pass=1. Then start in DONE begins a new run and clears done the next cycle.
